// File: rtl/execute_muldiv_unit.sv
// Iterative HI/LO multiply/divide engine for the Execute stage: radix-2 shift-add
// multiply, restoring divide, MADD/MSUB accumulate and MTHI/MTLO, with Busy/Done handshake.
module execute_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [2:0]            Op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         opnd_q, opnd_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 dbz_q, dbz_d;

  logic           op_signed;
  logic           op_div;
  logic           run_div;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     mul_sum;
  logic [W:0]     rem_shift;
  logic [W:0]     div_diff;
  logic [2*W-1:0] prod_signed;

  assign op_signed = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
  assign op_div    = (Op == OP_DIV) || (Op == OP_DIVU);
  assign run_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign a_mag     = (op_signed && A[W-1]) ? -A : A;
  assign b_mag     = (op_signed && B[W-1]) ? -B : B;

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  assign mul_sum     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
  assign rem_shift   = acc_q[2*W-1:W-1];
  assign div_diff    = rem_shift - {1'b0, opnd_q};
  assign prod_signed = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;

    case (state_q)
      RUN: begin
        if (dbz_q || (cnt_q == CNT_LAST)) begin
          state_d = FIN;
          if (!dbz_q) begin
            case (op_q)
              OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_signed;
              OP_MADD:           {hi_d, lo_d} = {hi_q, lo_q} + prod_signed;
              OP_MSUB:           {hi_d, lo_d} = {hi_q, lo_q} - prod_signed;
              OP_DIV, OP_DIVU: begin
                lo_d = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
                hi_d = rem_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
              end
              default: ;
            endcase
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (run_div) begin
            // Bit W of the difference is the borrow: set means the trial subtract is undone
            if (!div_diff[W]) begin
              acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
              acc_d = {rem_shift[W-1:0], acc_q[W-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum, acc_q[W-1:1]};
          end
        end
      end

      default: begin
        state_d = IDLE;
        if (Start) begin
          if (Op == OP_MTHI) begin
            hi_d = A;
          end else if (Op == OP_MTLO) begin
            lo_d = A;
          end else begin
            state_d   = RUN;
            cnt_d     = '0;
            op_d      = Op;
            neg_d     = op_signed && (A[W-1] ^ B[W-1]);
            rem_neg_d = op_signed && A[W-1];
            dbz_d     = op_div && (B == '0);
            acc_d     = op_div ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
            opnd_d    = op_div ? b_mag : a_mag;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
    end
  end

  assign Busy      = (state_q == RUN);
  assign Done      = (state_q == FIN);
  assign DivByZero = (state_q == FIN) && dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Scoreboard bench for execute_muldiv_unit: directed ops push hand-computed results,
// a negedge monitor pops and compares them whenever Done pulses.
module tb_execute_muldiv_unit;

  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  execute_muldiv_unit #(.DATA_WIDTH(W)) dut (
    .Clk(clk),
    .Reset(reset),
    .Start(start),
    .Op(op),
    .A(a),
    .B(b),
    .Busy(busy),
    .Done(done),
    .DivByZero(dbz),
    .Hi(hi),
    .Lo(lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Called at a negedge; the op is accepted at the following posedge.
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                               input logic edbz);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    if (push) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.dbz = edbz;
      e.cyc = cyc + (edbz ? 2 : W + 2);
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts Busy cycles, checks Hi/Lo hold mid-run, optionally injects a Start while busy.
  task automatic waitIdle(input string name, input int exp_busy, input logic [W-1:0] hold_hi,
                          input logic [W-1:0] hold_lo, input int inject_at, input logic [2:0] iop,
                          input logic [W-1:0] ia);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 2) begin
        checkOutput({name, "_hold_hi"}, 64'(hi), 64'(hold_hi));
        checkOutput({name, "_hold_lo"}, 64'(lo), 64'(hold_lo));
      end
      if (n == inject_at) begin
        start = 1'b1;
        op    = iop;
        a     = ia;
        b     = '0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    checkOutput({name, "_done"}, 64'(done), 64'd1);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("hi", 64'(hi), 64'(mon_e.hi));
        checkOutput("lo", 64'(lo), 64'(mon_e.lo));
        checkOutput("div_by_zero", 64'(dbz), 64'(mon_e.dbz));
        checkOutput("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end else if (dbz) begin
      checkOutput("dbz_without_done", 64'd1, 64'd0);
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_dbz", 64'(dbz), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // -3 * 5 = -15
    applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    waitIdle("mult", W + 1, 32'h0, 32'h0, -1, OP_MTHI, 32'h0);
    @(negedge clk);

    // Max unsigned squared; an MTHI issued while busy must be dropped
    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    waitIdle("multu", W + 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 9, OP_MTHI, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    checkOutput("multu_hi_after_ignored_start", 64'(hi), 64'hFFFFFFFE);

    // -7 / 2 = -3 rem -1
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    waitIdle("div", W + 1, 32'hFFFFFFFE, 32'h00000001, -1, OP_MTHI, 32'h0);
    @(negedge clk);

    // Divide by zero: one busy cycle, Hi/Lo untouched
    applyStimulus(OP_DIVU, 32'd7, 32'd0, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
    waitIdle("divu_zero", 1, 32'h0, 32'h0, -1, OP_MTHI, 32'h0);
    @(negedge clk);

    applyStimulus(OP_MTHI, 32'd0, 32'd0, 0, 32'h0, 32'h0, 1'b0);
    checkOutput("mthi_hi", 64'(hi), 64'd0);
    checkOutput("mthi_busy", 64'(busy), 64'd0);
    applyStimulus(OP_MTLO, 32'd10, 32'd0, 0, 32'h0, 32'h0, 1'b0);
    checkOutput("mtlo_lo", 64'(lo), 64'd10);
    checkOutput("mtlo_busy", 64'(busy), 64'd0);

    // {0,10} + 6 = 16, then 16 - 17 = -1
    applyStimulus(OP_MADD, 32'd2, 32'd3, 1, 32'h0, 32'd16, 1'b0);
    waitIdle("madd", W + 1, 32'h0, 32'd10, -1, OP_MTHI, 32'h0);
    @(negedge clk);
    applyStimulus(OP_MSUB, 32'd1, 32'd17, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    waitIdle("msub", W + 1, 32'h0, 32'd16, -1, OP_MTHI, 32'h0);
    @(negedge clk);

    // Reset mid-run aborts with no Done
    applyStimulus(OP_MULT, 32'd7, 32'd9, 0, 32'h0, 32'h0, 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_hi", 64'(hi), 64'd0);
    checkOutput("abort_lo", 64'(lo), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);
    checkOutput("abort_idle_busy", 64'(busy), 64'd0);

    applyStimulus(OP_MULTU, 32'd3, 32'd4, 1, 32'h0, 32'd12, 1'b0);
    waitIdle("multu_after_reset", W + 1, 32'h0, 32'h0, -1, OP_MTHI, 32'h0);
    @(negedge clk);

    // Back-to-back: second Start lands in the Done cycle of the first
    applyStimulus(OP_DIVU, 32'd9, 32'd2, 1, 32'd1, 32'd4, 1'b0);
    waitIdle("divu", W + 1, 32'h0, 32'd12, -1, OP_MTHI, 32'h0);
    applyStimulus(OP_MULTU, 32'd2, 32'd3, 1, 32'h0, 32'd6, 1'b0);
    waitIdle("b2b_multu", W + 1, 32'd1, 32'd4, -1, OP_MTHI, 32'h0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_unit.md
Name: execute_muldiv_unit

Overview:
- Parametrised, iterative HI/LO multiply/divide engine for the Execute stage.
- Generalises the single-cycle HiLo register path, which only supports write, MADD and MSUB.
- Adds multi-cycle signed/unsigned multiply, signed/unsigned divide, MTHI/MTLO, and a Busy/Done handshake.
- The hazard unit uses Busy/Done to stall mfhi/mflo and further muldiv issue.

Parameters:
- DATA_WIDTH, 32, operand width and width of each of HI and LO; must be ≥ 4.
- CNT_WIDTH, $clog2(DATA_WIDTH+1), width of the iteration counter.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  issue strobe, sampled on the rising edge.
- Op  in  3  operation code:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
  - 4 MADD (signed), 5 MSUB (signed), 6 MTHI, 7 MTLO
- A  in  DATA_WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- B  in  DATA_WIDTH  rt operand (divisor / multiplier).
- Busy  out  1  high while an iterative operation is in flight.
- Done  out  1  one-cycle pulse when HI/LO have been updated by an iterative op.
- DivByZero  out  1  one-cycle pulse, coincident with Done, for DIV/DIVU with B == 0.
- Hi  out  DATA_WIDTH  current HI register.
- Lo  out  DATA_WIDTH  current LO register.

Behaviour:
- Reset: Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, FSM=IDLE, counter=0.
  - Reset overrides Start in the same cycle.
  - Reset aborts any in-flight op; no Done is produced.
- FSM states IDLE, RUN, FIN.
- Issue:
  - Start is accepted only in IDLE or FIN. Start while Busy=1 is ignored; Hi/Lo are unaffected.
  - Back-to-back issue is allowed: Start in the Done cycle is accepted.
- MTHI/MTLO:
  - Hi (resp. Lo) <= A at the accepting edge.
  - No Busy, no Done; FSM stays in or returns to IDLE.
  - Updated value is visible the next cycle.
- Iterative ops (0-5), accepted at edge E:
  - IDLE/FIN -> RUN at E. Operand magnitudes and result signs are latched at E:
    - signed ops: sign = A[MSB] ^ B[MSB] for the quotient/product;
    - the remainder takes the sign of A.
  - RUN: one radix-2 step per edge, for DATA_WIDTH edges (E+1 .. E+DATA_WIDTH).
    - Multiply: shift-add.
    - Divide: restoring.
  - RUN -> FIN at edge E+DATA_WIDTH+1. At that edge:
    - sign fix-up is applied;
    - Hi/Lo are written;
    - Busy falls and Done=1 for that cycle.
  - FIN -> IDLE on the next edge unless a new Start is accepted.
  - Busy=1 for exactly DATA_WIDTH+1 cycles. Done asserts DATA_WIDTH+1 cycles after the issue edge (33 for width 32).
  - Hi/Lo hold their old values throughout RUN; they are written only at FIN entry.
- Results:
  - MULT/MULTU: {Hi,Lo} = full 2*DATA_WIDTH product.
  - MADD: {Hi,Lo} <= {Hi,Lo} + signed(A*B), modulo 2^(2*DATA_WIDTH).
  - MSUB: {Hi,Lo} <= {Hi,Lo} - signed(A*B), modulo 2^(2*DATA_WIDTH).
  - MADD/MSUB use the {Hi,Lo} value present at FIN entry.
  - DIV/DIVU: Lo = quotient truncated toward zero; Hi = remainder.
  - Signed DIV of most-negative / -1: Lo = most-negative, Hi = 0, no flag.
- Divide by zero (DIV/DIVU with B == 0):
  - Detected at E; skips RUN. FSM -> FIN at edge E+1.
  - Done=1 and DivByZero=1 for one cycle; Busy=1 only for the cycle after E.
  - Hi/Lo unchanged.
- Op codes outside 0-7 cannot occur (3-bit field). Start with any Op while in FIN is legal.

Test Plan:
- Reset, then MULT A=0xFFFFFFFD(-3), B=5 -> Busy for 33 cycles; Done at cycle 33 with Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; DivByZero=0.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; a second Start issued at cycle 10 (Busy) is ignored and yields no extra Done.
- DIV A=0xFFFFFFF9(-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; then DIVU A=7, B=0 -> Done and DivByZero high 1 cycle after issue, Hi/Lo unchanged.
- Sequence:
  - MTHI 0 then MTLO 10 (Busy stays 0, values visible the next cycle);
  - MADD A=2, B=3 -> Hi=0, Lo=16;
  - MSUB A=1, B=17 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF.
- MULT issued; Reset asserted at cycle 10 for one cycle -> Hi=Lo=0, Busy=0, no Done ever. MULTU 3*4 issued after reset -> Lo=12.
- Back-to-back: Start MULTU 2*3 issued in the Done cycle of a prior DIVU 9/2 -> first result Lo=4, Hi=1; second Done 33 cycles later with Lo=6, Hi=0.
